// File: rtl/bsnn_pkg.sv
// Shared types and constants for the binary-weight integrate-and-fire neuron.
package bsnn_pkg;

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StIntegrate = 2'd1,
      StDone      = 2'd2
   } state_t;

   // Saturation limits of a signed value of the given width.
   function automatic int sat_hi(input int unsigned width);
      return (2 ** (width - 1)) - 1;
   endfunction

   function automatic int sat_lo(input int unsigned width);
      return -(2 ** (width - 1));
   endfunction

   // All-ones spike time means the neuron did not fire in the window.
   function automatic logic [31:0] no_fire_time(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/bsnn_signed_popcount.sv
// Signed popcount: +1 per active synapse with weight 1, -1 per active synapse with weight 0.
module bsnn_signed_popcount #(
   parameter int unsigned N_IN = 8
) (
   input  logic [N_IN-1:0]              spikes,
   input  logic [N_IN-1:0]              weights,
   output logic signed [$clog2(N_IN)+1:0] delta
);

   localparam int unsigned DW = $clog2(N_IN) + 2;

   logic [DW-1:0] w_pos;
   logic [DW-1:0] w_neg;

   always_comb begin
      w_pos = '0;
      w_neg = '0;
      for (int i = 0; i < N_IN; i++) begin
         w_pos = w_pos + {{(DW-1){1'b0}}, spikes[i] & weights[i]};
         w_neg = w_neg + {{(DW-1){1'b0}}, spikes[i] & ~weights[i]};
      end
   end

   assign delta = $signed(w_pos - w_neg);

endmodule

// File: rtl/bsnn_if_neuron.sv
// Integrate-and-fire neuron with binary weights; fires at most once per window and
// reports the integration index of the first threshold crossing.
module bsnn_if_neuron
   import bsnn_pkg::*;
#(
   parameter int unsigned N_IN      = 8,
   parameter int unsigned POT_WIDTH = 8,
   parameter int unsigned WIN_WIDTH = 5
) (
   input  logic                        CLK,
   input  logic                        nRES,
   input  logic                        start,
   input  logic [WIN_WIDTH-1:0]        window_len,
   input  logic signed [POT_WIDTH-1:0] threshold,
   input  logic [N_IN-1:0]             weights,
   input  logic [N_IN-1:0]             spikes_in,
   output logic                        spike_out,
   output logic                        fired,
   output logic [WIN_WIDTH-1:0]        spike_time,
   output logic signed [POT_WIDTH-1:0] potential,
   output logic                        busy,
   output logic                        done
);

   localparam int unsigned DW = $clog2(N_IN) + 2;
   localparam logic signed [POT_WIDTH:0] SatHi = (POT_WIDTH+1)'(sat_hi(POT_WIDTH));
   localparam logic signed [POT_WIDTH:0] SatLo = (POT_WIDTH+1)'(sat_lo(POT_WIDTH));
   localparam logic [WIN_WIDTH-1:0]      NoFire = WIN_WIDTH'(no_fire_time(WIN_WIDTH));

   state_t                        r_state;
   state_t                        w_state_nxt;
   logic [WIN_WIDTH-1:0]          r_timer;
   logic [WIN_WIDTH-1:0]          r_idx;
   logic signed [POT_WIDTH-1:0]   r_thr;
   logic signed [POT_WIDTH-1:0]   r_pot;
   logic                          r_fired;
   logic                          r_spike_out;
   logic [WIN_WIDTH-1:0]          r_spike_time;

   logic signed [DW-1:0]          w_delta;
   logic signed [POT_WIDTH:0]     w_sum;
   logic signed [POT_WIDTH-1:0]   w_pot_sat;
   logic                          w_fire;

   bsnn_signed_popcount #(
      .N_IN (N_IN)
   ) u_popcount (
      .spikes  (spikes_in),
      .weights (weights),
      .delta   (w_delta)
   );

   // One extra bit of headroom so the clamp sees the true sum.
   assign w_sum = {r_pot[POT_WIDTH-1], r_pot}
                + {{(POT_WIDTH+1-DW){w_delta[DW-1]}}, w_delta};

   always_comb begin
      w_pot_sat = w_sum[POT_WIDTH-1:0];
      if (w_sum > SatHi) begin
         w_pot_sat = SatHi[POT_WIDTH-1:0];
      end else if (w_sum < SatLo) begin
         w_pot_sat = SatLo[POT_WIDTH-1:0];
      end
   end

   assign w_fire = (r_state == StIntegrate) && !r_fired && (w_pot_sat >= r_thr);

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_state_nxt = (window_len == '0) ? StDone : StIntegrate;
            end
         end
         StIntegrate: begin
            busy = 1'b1;
            if (r_timer == WIN_WIDTH'(1)) begin
               w_state_nxt = StDone;
            end
         end
         StDone: begin
            done        = 1'b1;
            w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         r_state      <= StIdle;
         r_timer      <= '0;
         r_idx        <= '0;
         r_thr        <= '0;
         r_pot        <= '0;
         r_fired      <= 1'b0;
         r_spike_out  <= 1'b0;
         r_spike_time <= NoFire;
      end else begin
         r_state     <= w_state_nxt;
         r_spike_out <= 1'b0;
         case (r_state)
            StIdle: begin
               if (start) begin
                  r_timer      <= window_len;
                  r_thr        <= threshold;
                  r_pot        <= '0;
                  r_fired      <= 1'b0;
                  r_spike_time <= NoFire;
                  r_idx        <= '0;
               end
            end
            StIntegrate: begin
               r_pot   <= w_pot_sat;
               r_timer <= r_timer - WIN_WIDTH'(1);
               r_idx   <= r_idx + WIN_WIDTH'(1);
               if (w_fire) begin
                  r_spike_out  <= 1'b1;
                  r_fired      <= 1'b1;
                  r_spike_time <= r_idx;
               end
            end
            default: ;
         endcase
      end
   end

   assign spike_out  = r_spike_out;
   assign fired      = r_fired;
   assign spike_time = r_spike_time;
   assign potential  = r_pot;

endmodule
